seg7_scan_decoder: RTL and testbench

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_scan_decoder.sv | 183 ++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Purpose:
//   Snoops a multiplexed 4-digit, 7-segment display bus (active-low anodes and
//   segments) and recovers the value shown on each digit. A digit's output
//   only updates once the same pattern has been sampled STABLE_CNT times in a
//   row for that digit, which filters ghosting during anode transitions.
//   frame_valid pulses once all four digits have stabilised since the last
//   pulse.
//
// Parameters:
//   STABLE_CNT   consecutive identical samples needed per digit (1..15)
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset (overrides strobe)
//   strobe       sample enable for anode/sseg
//   anode[3:0]   active-low digit select, bit i low selects digit i
//   sseg[6:0]    active-low segments, bit6=a ... bit0=g
//   digit0..3    decoded values: 0..9 (0..15 with hex), 5'h10 = blank
//   frame_valid  one-cycle pulse when all four digits have stabilised
//   seg_err      one-cycle pulse after an unrecognised segment pattern
//   bus_err      one-cycle pulse after a strobe without exactly one anode low
//
// Configuration:
//   SEG_DECODE_HEX_EN  when defined, also decodes A,b,C,d,E,F as 10..15
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter int STABLE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe,
  input  logic [3:0] anode,
  input  logic [6:0] sseg,
  output logic [4:0] digit0,
  output logic [4:0] digit1,
  output logic [4:0] digit2,
  output logic [4:0] digit3,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       bus_err
);

  localparam logic [3:0] STABLE_N   = 4'(STABLE_CNT);
  localparam logic [4:0] CODE_BLANK = 5'h10;
  localparam logic [4:0] CODE_BAD   = 5'h1F;

  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] c;
    case (s)
      7'b0000001: c = 5'd0;
      7'b1001111: c = 5'd1;
      7'b0010010: c = 5'd2;
      7'b0000110: c = 5'd3;
      7'b1001100: c = 5'd4;
      7'b0100100: c = 5'd5;
      7'b0100000: c = 5'd6;
      7'b0001111: c = 5'd7;
      7'b0000000: c = 5'd8;
      7'b0000100: c = 5'd9;
      7'b1111111: c = CODE_BLANK;
`ifdef SEG_DECODE_HEX_EN
      7'b0001000: c = 5'd10;
      7'b1100000: c = 5'd11;
      7'b0110001: c = 5'd12;
      7'b1000010: c = 5'd13;
      7'b0110000: c = 5'd14;
      7'b0111000: c = 5'd15;
`endif
      default:    c = CODE_BAD;
    endcase
    return c;
  endfunction

  logic [4:0] code;
  logic       sel_ok;       // exactly one anode driven low
  logic       sample_ok;
  logic       sample_bad;
  logic [3:0] stable_hit;   // digit reached stability with a loadable code
  logic [4:0] digit_vals [4];

  logic [3:0] seen_reg, seen_next;
  logic       frame_reg, frame_next;
  logic       seg_err_reg, seg_err_next;
  logic       bus_err_reg, bus_err_next;

  assign code       = decode_seg(sseg);
  assign sel_ok     = $onehot(~anode);
  assign sample_ok  = strobe & sel_ok;
  assign sample_bad = strobe & ~sel_ok;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [4:0] cand_reg, cand_next;
      logic [3:0] cnt_reg, cnt_next;
      logic [4:0] digit_reg, digit_next;
      logic       hit;

      always_comb begin
        cand_next  = cand_reg;
        cnt_next   = cnt_reg;
        digit_next = digit_reg;
        hit        = 1'b0;
        if (sample_ok && !anode[gi]) begin
          if (code == cand_reg) begin
            // Saturating count; stability fires only on the transition to
            // STABLE_N so a held pattern does not retrigger.
            if (cnt_reg != STABLE_N) begin
              cnt_next = cnt_reg + 4'd1;
              hit      = (cnt_reg + 4'd1 == STABLE_N);
            end
          end else begin
            cand_next = code;
            cnt_next  = 4'd1;
            hit       = (STABLE_N == 4'd1);
          end
          // A stable unrecognised pattern is never shown and never counts
          // toward a frame.
          if (code == CODE_BAD) begin
            hit = 1'b0;
          end
          if (hit) begin
            digit_next = code;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cand_reg  <= CODE_BAD;
          cnt_reg   <= 4'd0;
          digit_reg <= CODE_BLANK;
        end else begin
          cand_reg  <= cand_next;
          cnt_reg   <= cnt_next;
          digit_reg <= digit_next;
        end
      end

      assign digit_vals[gi] = digit_reg;
      assign stable_hit[gi] = hit;
    end
  endgenerate

  always_comb begin
    seen_next  = seen_reg | stable_hit;
    frame_next = 1'b0;
    if (seen_reg == 4'hF) begin
      // Clear on the pulse edge, but keep any digit stabilising right now
      // so it counts toward the next frame.
      frame_next = 1'b1;
      seen_next  = stable_hit;
    end
    bus_err_next = sample_bad;
    seg_err_next = sample_ok && (code == CODE_BAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_reg    <= 4'd0;
      frame_reg   <= 1'b0;
      seg_err_reg <= 1'b0;
      bus_err_reg <= 1'b0;
    end else begin
      seen_reg    <= seen_next;
      frame_reg   <= frame_next;
      seg_err_reg <= seg_err_next;
      bus_err_reg <= bus_err_next;
    end
  end

  assign digit0      = digit_vals[0];
  assign digit1      = digit_vals[1];
  assign digit2      = digit_vals[2];
  assign digit3      = digit_vals[3];
  assign frame_valid = frame_reg;
  assign seg_err     = seg_err_reg;
  assign bus_err     = bus_err_reg;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Directed self-checking bench for seg7_scan_decoder (STABLE_CNT = 3).
// Inputs change on the falling edge; outputs are checked on the falling edge
// following the rising edge that captured a sample.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

  logic       clk;
  logic       rst;
  logic       strobe;
  logic [3:0] anode;
  logic [6:0] sseg;
  logic [4:0] digit0, digit1, digit2, digit3;
  logic       frame_valid, seg_err, bus_err;

  int n_checks = 0;
  int n_fail   = 0;
  int fv_total = 0;

  logic [6:0] pat [0:9];
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_JUNK  = 7'b1110111;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;

  seg7_scan_decoder #(.STABLE_CNT(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .strobe      (strobe),
    .anode       (anode),
    .sseg        (sseg),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts frame_valid pulses; read only on falling edges.
  always @(posedge clk) begin
    if (frame_valid === 1'b1) fv_total++;
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; strobe = 1'b0; anode = 4'hF; sseg = SEG_BLANK;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One strobed sample, followed by one idle cycle.
  task automatic do_strobe(input logic [3:0] an, input logic [6:0] sg);
    @(negedge clk);
    strobe = 1'b1; anode = an; sseg = sg;
    @(negedge clk);
    strobe = 1'b0; anode = 4'hF;
    $display("strobe anode=%b sseg=%b -> d0=%h d1=%h d2=%h d3=%h fv=%b se=%b be=%b",
             an, sg, digit0, digit1, digit2, digit3, frame_valid, seg_err, bus_err);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (digit0 !== 5'h10) begin n_fail++; $display("FAIL reset_d0 got %h want 10", digit0); end
    n_checks++; if (digit1 !== 5'h10) begin n_fail++; $display("FAIL reset_d1 got %h want 10", digit1); end
    n_checks++; if (digit2 !== 5'h10) begin n_fail++; $display("FAIL reset_d2 got %h want 10", digit2); end
    n_checks++; if (digit3 !== 5'h10) begin n_fail++; $display("FAIL reset_d3 got %h want 10", digit3); end
    n_checks++; if ({frame_valid, seg_err, bus_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b want 000", {frame_valid, seg_err, bus_err});
    end
  endtask

  task automatic test_stable_digit0();
    apply_reset();
    do_strobe(4'b1110, pat[2]);
    do_strobe(4'b1110, pat[2]);
    n_checks++; if (digit0 !== 5'h10) begin n_fail++; $display("FAIL stab_d0_after2 got %h want 10", digit0); end
    do_strobe(4'b1110, pat[2]);
    n_checks++; if (digit0 !== 5'd2) begin n_fail++; $display("FAIL stab_d0_after3 got %h want 02", digit0); end
    n_checks++; if (seg_err !== 1'b0) begin n_fail++; $display("FAIL stab_seg_err got %b want 0", seg_err); end
  endtask

  task automatic test_digit1_change();
    apply_reset();
    do_strobe(4'b1101, pat[1]);
    do_strobe(4'b1101, pat[1]);
    n_checks++; if (digit1 !== 5'h10) begin n_fail++; $display("FAIL chg_d1_after2 got %h want 10", digit1); end
    do_strobe(4'b1101, pat[3]);
    do_strobe(4'b1101, pat[3]);
    n_checks++; if (digit1 !== 5'h10) begin n_fail++; $display("FAIL chg_d1_after4 got %h want 10", digit1); end
    do_strobe(4'b1101, pat[3]);
    n_checks++; if (digit1 !== 5'd3) begin n_fail++; $display("FAIL chg_d1_after5 got %h want 03", digit1); end
    n_checks++; if (digit0 !== 5'h10) begin n_fail++; $display("FAIL chg_d0_untouched got %h want 10", digit0); end
  endtask

  task automatic test_decode_all();
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      repeat (3) do_strobe(4'b1110, pat[k]);
      n_checks++; if (digit0 !== 5'(k)) begin n_fail++; $display("FAIL decode_%0d got %h want %h", k, digit0, 5'(k)); end
    end
    repeat (3) do_strobe(4'b1110, SEG_BLANK);
    n_checks++; if (digit0 !== 5'h10) begin n_fail++; $display("FAIL decode_blank got %h want 10", digit0); end
    n_checks++; if (seg_err !== 1'b0) begin n_fail++; $display("FAIL decode_blank_seg_err got %b want 0", seg_err); end
  endtask

  task automatic test_frame();
    int base;
    apply_reset();
    base = fv_total;
    for (int r = 0; r < 3; r++) begin
      do_strobe(4'b1110, pat[5]);
      do_strobe(4'b1101, pat[6]);
      do_strobe(4'b1011, pat[7]);
      do_strobe(4'b0111, pat[8]);
    end
    n_checks++; if ({digit0, digit1, digit2, digit3} !== {5'd5, 5'd6, 5'd7, 5'd8}) begin
      n_fail++; $display("FAIL frame_digits got %h %h %h %h want 05 06 07 08", digit0, digit1, digit2, digit3);
    end
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL frame_early got %b want 0", frame_valid); end
    @(negedge clk);
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL frame_pulse got %b want 1", frame_valid); end
    @(negedge clk);
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL frame_pulse_end got %b want 0", frame_valid); end
    repeat (3) @(negedge clk);
    n_checks++; if (fv_total - base !== 1) begin n_fail++; $display("FAIL frame_count got %0d want 1", fv_total - base); end
    // seen must have been cleared: three fresh digits alone give no frame.
    for (int r = 0; r < 3; r++) begin
      do_strobe(4'b1110, pat[1]);
      do_strobe(4'b1101, pat[2]);
      do_strobe(4'b1011, pat[3]);
    end
    repeat (3) @(negedge clk);
    n_checks++; if (fv_total - base !== 1) begin n_fail++; $display("FAIL frame_seen_cleared got %0d want 1", fv_total - base); end
    repeat (3) do_strobe(4'b0111, pat[4]);
    repeat (3) @(negedge clk);
    n_checks++; if (fv_total - base !== 2) begin n_fail++; $display("FAIL frame_second got %0d want 2", fv_total - base); end
  endtask

  task automatic test_errors();
    int base;
    apply_reset();
    base = fv_total;
    repeat (3) do_strobe(4'b1011, pat[7]);
    for (int r = 0; r < 3; r++) begin
      do_strobe(4'b1011, SEG_JUNK);
      n_checks++; if ({seg_err, bus_err} !== 2'b10) begin
        n_fail++; $display("FAIL seg_err_pulse_%0d got %b want 10", r, {seg_err, bus_err});
      end
    end
    n_checks++; if (digit2 !== 5'd7) begin n_fail++; $display("FAIL seg_err_d2_kept got %h want 07", digit2); end
    @(negedge clk);
    n_checks++; if (seg_err !== 1'b0) begin n_fail++; $display("FAIL seg_err_one_cycle got %b want 0", seg_err); end
    // A bus error between samples must not disturb the running count.
    do_strobe(4'b1110, pat[4]);
    do_strobe(4'b1110, pat[4]);
    do_strobe(4'b1100, pat[9]);
    n_checks++; if ({seg_err, bus_err} !== 2'b01) begin n_fail++; $display("FAIL bus_err_two_low got %b want 01", {seg_err, bus_err}); end
    do_strobe(4'b1111, pat[9]);
    n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL bus_err_none_low got %b want 1", bus_err); end
    do_strobe(4'b1100, SEG_JUNK);
    n_checks++; if ({seg_err, bus_err} !== 2'b01) begin n_fail++; $display("FAIL bus_err_precedence got %b want 01", {seg_err, bus_err}); end
    n_checks++; if ({digit0, digit1} !== {5'h10, 5'h10}) begin
      n_fail++; $display("FAIL bus_err_no_update got %h %h want 10 10", digit0, digit1);
    end
    do_strobe(4'b1110, pat[4]);
    n_checks++; if (digit0 !== 5'd4) begin n_fail++; $display("FAIL bus_err_count_kept got %h want 04", digit0); end
    @(negedge clk);
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL bus_err_one_cycle got %b want 0", bus_err); end
    // Stable junk on digit3 must not mark it seen.
    repeat (3) do_strobe(4'b1101, pat[1]);
    repeat (3) do_strobe(4'b0111, SEG_JUNK);
    repeat (3) @(negedge clk);
    n_checks++; if (fv_total - base !== 0) begin n_fail++; $display("FAIL junk_not_seen got %0d want 0", fv_total - base); end
    repeat (3) do_strobe(4'b0111, SEG_BLANK);
    repeat (3) @(negedge clk);
    n_checks++; if (fv_total - base !== 1) begin n_fail++; $display("FAIL blank_completes_frame got %0d want 1", fv_total - base); end
  endtask

  task automatic test_hex();
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      do_strobe(4'b0111, SEG_HEX_A);
`ifdef SEG_DECODE_HEX_EN
      n_checks++; if (seg_err !== 1'b0) begin n_fail++; $display("FAIL hex_seg_err_%0d got %b want 0", r, seg_err); end
`else
      n_checks++; if (seg_err !== 1'b1) begin n_fail++; $display("FAIL hex_seg_err_%0d got %b want 1", r, seg_err); end
`endif
    end
`ifdef SEG_DECODE_HEX_EN
    n_checks++; if (digit3 !== 5'd10) begin n_fail++; $display("FAIL hex_d3 got %h want 0a", digit3); end
`else
    n_checks++; if (digit3 !== 5'h10) begin n_fail++; $display("FAIL hex_d3 got %h want 10", digit3); end
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    repeat (3) do_strobe(4'b1101, pat[9]);
    do_strobe(4'b1110, pat[2]);
    do_strobe(4'b1110, pat[2]);
    // Reset on the same edge as the would-be third sample.
    @(negedge clk);
    rst = 1'b1; strobe = 1'b1; anode = 4'b1110; sseg = pat[2];
    @(negedge clk);
    rst = 1'b0; strobe = 1'b0; anode = 4'hF;
    $display("reset with strobe anode=1110 sseg=%b -> d0=%h d1=%h", pat[2], digit0, digit1);
    n_checks++; if ({digit0, digit1, digit2, digit3} !== {4{5'h10}}) begin
      n_fail++; $display("FAIL rstmid_digits got %h %h %h %h want 10 10 10 10", digit0, digit1, digit2, digit3);
    end
    n_checks++; if ({frame_valid, seg_err, bus_err} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_flags got %b want 000", {frame_valid, seg_err, bus_err});
    end
    do_strobe(4'b1110, pat[2]);
    do_strobe(4'b1110, pat[2]);
    n_checks++; if (digit0 !== 5'h10) begin n_fail++; $display("FAIL rstmid_after2 got %h want 10", digit0); end
    do_strobe(4'b1110, pat[2]);
    n_checks++; if (digit0 !== 5'd2) begin n_fail++; $display("FAIL rstmid_after3 got %h want 02", digit0); end
  endtask

  initial begin
    rst = 1'b1; strobe = 1'b0; anode = 4'hF; sseg = SEG_BLANK;
    pat[0] = 7'b0000001; pat[1] = 7'b1001111; pat[2] = 7'b0010010;
    pat[3] = 7'b0000110; pat[4] = 7'b1001100; pat[5] = 7'b0100100;
    pat[6] = 7'b0100000; pat[7] = 7'b0001111; pat[8] = 7'b0000000;
    pat[9] = 7'b0000100;
    test_reset();
    test_stable_digit0();
    test_digit1_change();
    test_decode_all();
    test_frame();
    test_errors();
    test_hex();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
